// File: rtl/quad_step_decoder.sv
// quad_step_decoder
// Decodes a two-phase quadrature encoder (A/B) into one-cycle step pulses and
// a direction level for the downstream mod-N up/down counter.
// Build option: define QUAD_X4_EN to pulse on every legal step (x4 mode).
// Without it (x1 mode), only steps into phase 00 produce a pulse.
module quad_step_decoder #(
   parameter int DEB_CYCLES = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_a,
   input  logic i_b,
   input  logic i_clr,
   output logic o_en,
   output logic o_up_down,
   output logic o_err
);

   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_INIT = 3'd0,
      ST_S00  = 3'd1,
      ST_S01  = 3'd2,
      ST_S11  = 3'd3,
      ST_S10  = 3'd4
   } state_t;

   // Phase code {a,b} held by each phase state.
   function automatic logic [1:0] state_code(input state_t st);
      logic [1:0] code;
      case (st)
         ST_S00:  code = 2'b00;
         ST_S01:  code = 2'b01;
         ST_S11:  code = 2'b11;
         ST_S10:  code = 2'b10;
         default: code = 2'b00;
      endcase
      return code;
   endfunction

   // Phase state matching a {a,b} code.
   function automatic state_t code_state(input logic [1:0] code);
      state_t st;
      case (code)
         2'b00:   st = ST_S00;
         2'b01:   st = ST_S01;
         2'b11:   st = ST_S11;
         2'b10:   st = ST_S10;
         default: st = ST_INIT;
      endcase
      return st;
   endfunction

   // Position of a code along the clockwise cycle 00->01->11->10.
   function automatic logic [1:0] gray_idx(input logic [1:0] code);
      return {code[1], code[1] ^ code[0]};
   endfunction

   // True when nxt is one clockwise (up) step after cur.
   function automatic logic is_forward(input logic [1:0] cur, input logic [1:0] nxt);
      logic [1:0] cur_plus;
      cur_plus = gray_idx(cur) + 2'd1;
      return (gray_idx(nxt) == cur_plus);
   endfunction

   logic          a_meta_r;
   logic          a_sync_r;
   logic          b_meta_r;
   logic          b_sync_r;
   logic [1:0]    sync_vld_r;
   logic [1:0]    f_r;
   logic [CW-1:0] deb_cnt_r;
   state_t        state_r;

   logic [1:0]    s_s;
   logic [1:0]    s_nxt_s;
   logic [1:0]    cur_code_s;
   logic          step_s;
   logic          illegal_s;
   logic          fwd_s;
   logic          pulse_s;

   // Two-flop synchronisers; sync_vld_r marks when the chain holds real pin
   // values so the phase is never seeded from the reset value of the flops.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         a_meta_r   <= 1'b0;
         a_sync_r   <= 1'b0;
         b_meta_r   <= 1'b0;
         b_sync_r   <= 1'b0;
         sync_vld_r <= 2'b00;
      end else begin
         a_meta_r   <= i_a;
         a_sync_r   <= a_meta_r;
         b_meta_r   <= i_b;
         b_sync_r   <= b_meta_r;
         sync_vld_r <= {sync_vld_r[0], 1'b1};
      end
   end

   // Classify the pending step between the current phase and the filtered pair.
   always_comb begin
      s_s        = {a_sync_r, b_sync_r};
      s_nxt_s    = {a_meta_r, b_meta_r};
      cur_code_s = state_code(state_r);
      step_s     = 1'b0;
      illegal_s  = 1'b0;
      fwd_s      = 1'b0;
      pulse_s    = 1'b0;
      if ((state_r != ST_INIT) && (f_r != cur_code_s)) begin
         step_s    = 1'b1;
         illegal_s = ((f_r ^ cur_code_s) == 2'b11);
         fwd_s     = is_forward(cur_code_s, f_r);
`ifdef QUAD_X4_EN
         pulse_s   = !illegal_s;
`else
         pulse_s   = !illegal_s && (f_r == 2'b00);
`endif
      end else begin
         step_s    = 1'b0;
         illegal_s = 1'b0;
      end
   end

   // Joint debounce: s_s must hold a new value DEB_CYCLES edges before f_r takes it.
   // s_nxt_s != s_s means the synchronised pair changes on this edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         f_r       <= 2'b00;
         deb_cnt_r <= CNT_ZERO;
      end else if (i_clr) begin
         deb_cnt_r <= CNT_ZERO;
      end else if (state_r == ST_INIT) begin
         deb_cnt_r <= CNT_ZERO;
         if (sync_vld_r[1]) begin
            f_r <= s_s;
         end
      end else if ((s_nxt_s != s_s) || (s_s == f_r)) begin
         deb_cnt_r <= CNT_ZERO;
      end else if (deb_cnt_r == CNT_LAST) begin
         f_r       <= s_s;
         deb_cnt_r <= CNT_ZERO;
      end else begin
         deb_cnt_r <= deb_cnt_r + CNT_ONE;
      end
   end

   // Phase FSM with registered step pulse, direction and sticky error.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r   <= ST_INIT;
         o_en      <= 1'b0;
         o_up_down <= 1'b1;
         o_err     <= 1'b0;
      end else if (i_clr) begin
         state_r   <= ST_INIT;
         o_en      <= 1'b0;
         o_err     <= 1'b0;
      end else begin
         o_en <= 1'b0;
         case (state_r)
            ST_INIT: begin
               if (sync_vld_r[1]) begin
                  state_r <= code_state(s_s);
               end
            end
            ST_S00, ST_S01, ST_S11, ST_S10: begin
               if (step_s) begin
                  state_r <= code_state(f_r);
                  if (illegal_s) begin
                     o_err <= 1'b1;
                  end else if (pulse_s) begin
                     o_en      <= 1'b1;
                     o_up_down <= fwd_s;
                  end
               end
            end
            default: begin
               state_r <= ST_INIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder (DEB_CYCLES = 4); works in both the
// x1 build and the QUAD_X4_EN build.
module tb_quad_step_decoder;

`ifdef QUAD_X4_EN
   localparam bit X4 = 1'b1;
`else
   localparam bit X4 = 1'b0;
`endif

   logic i_clk = 1'b0;
   logic i_rst_n = 1'b0;
   logic i_a = 1'b0;
   logic i_b = 1'b0;
   logic i_clr = 1'b0;
   logic o_en;
   logic o_up_down;
   logic o_err;

   int n_checks = 0;
   int n_errors = 0;

   quad_step_decoder #(.DEB_CYCLES(4)) dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_a       (i_a),
      .i_b       (i_b),
      .i_clr     (i_clr),
      .o_en      (o_en),
      .o_up_down (o_up_down),
      .o_err     (o_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic run_seg(input logic [1:0] ab, input int n, output int pulses, output int ups);
      {i_a, i_b} = ab;
      pulses = 0;
      ups = 0;
      for (int k = 0; k < n; k++) begin
         tick();
         if (o_en) begin
            pulses++;
            if (o_up_down) ups++;
         end
      end
   endtask

   initial begin
      int p;
      int u;
      logic [1:0] cw_seq [4];
      cw_seq = '{2'b01, 2'b11, 2'b10, 2'b00};

      // Reset state
      repeat (3) tick();
      check_eq("rst_en", o_en, 1'b0);
      check_eq("rst_dir", o_up_down, 1'b1);
      check_eq("rst_err", o_err, 1'b0);
      i_rst_n = 1'b1;
      run_seg(2'b00, 8, p, u);
      check_eq("seed_nopulse", p, 0);

      // Full clockwise cycle
      for (int i = 0; i < 4; i++) begin
         run_seg(cw_seq[i], 10, p, u);
         check_eq($sformatf("cw_pulses_%0d", i), p, (X4 || i == 3) ? 1 : 0);
         check_eq($sformatf("cw_up_%0d", i), u, (X4 || i == 3) ? 1 : 0);
      end
      check_eq("cw_err", o_err, 1'b0);

      // Latency on a 10->00 (up) step: pulse only after edge 6
      run_seg(2'b10, 10, p, u);
      check_eq("rev_pulses", p, X4 ? 1 : 0);
      check_eq("rev_ups", u, 0);
      {i_a, i_b} = 2'b00;
      for (int k = 0; k <= 8; k++) begin
         tick();
         check_eq($sformatf("lat_en_e%0d", k), o_en, (k == 6) ? 1'b1 : 1'b0);
         if (k == 6 || k == 7) check_eq($sformatf("lat_dir_e%0d", k), o_up_down, 1'b1);
      end
      run_seg(2'b00, 3, p, u);

      // Bounce rejection
      run_seg(2'b10, 3, p, u);
      check_eq("bnc_p1", p, 0);
      run_seg(2'b00, 1, p, u);
      check_eq("bnc_p2", p, 0);
      run_seg(2'b10, 3, p, u);
      check_eq("bnc_p3", p, 0);
      run_seg(2'b00, 12, p, u);
      check_eq("bnc_p4", p, 0);
      check_eq("bnc_f", dut.f_r, 2'b00);
      check_eq("bnc_err", o_err, 1'b0);

      // Illegal jump 00->11, then clear
      run_seg(2'b11, 10, p, u);
      check_eq("ill_pulses", p, 0);
      check_eq("ill_err", o_err, 1'b1);
      check_eq("ill_dir", o_up_down, 1'b1);
      check_eq("ill_f", dut.f_r, 2'b11);
      i_clr = 1'b1;
      tick();
      i_clr = 1'b0;
      check_eq("clr_err", o_err, 1'b0);
      check_eq("clr_en", o_en, 1'b0);
      run_seg(2'b11, 5, p, u);
      check_eq("clr_seed_pulses", p, 0);
      run_seg(2'b10, 10, p, u);
      check_eq("post_clr_pulses", p, X4 ? 1 : 0);
      check_eq("post_clr_ups", u, X4 ? 1 : 0);
      check_eq("post_clr_err", o_err, 1'b0);

      // Set err and down direction, then reset mid-debounce
      run_seg(2'b01, 10, p, u);
      check_eq("ill2_pulses", p, 0);
      check_eq("ill2_err", o_err, 1'b1);
      run_seg(2'b00, 10, p, u);
      check_eq("down_pulses", p, 1);
      check_eq("down_ups", u, 0);
      check_eq("down_dir", o_up_down, 1'b0);
      run_seg(2'b11, 4, p, u);
      check_eq("mid_cnt", dut.deb_cnt_r, 2);
      i_rst_n = 1'b0;
      #1;
      check_eq("mid_rst_en", o_en, 1'b0);
      check_eq("mid_rst_dir", o_up_down, 1'b1);
      check_eq("mid_rst_err", o_err, 1'b0);
      check_eq("mid_rst_cnt", dut.deb_cnt_r, 0);
      repeat (3) tick();
      i_rst_n = 1'b1;
      run_seg(2'b11, 12, p, u);
      check_eq("rel_pulses", p, 0);
      check_eq("rel_err", o_err, 1'b0);
      check_eq("rel_f", dut.f_r, 2'b11);

      // Direction reversal 00->01->00
      run_seg(2'b10, 10, p, u);
      check_eq("go10_pulses", p, X4 ? 1 : 0);
      run_seg(2'b00, 10, p, u);
      check_eq("go00_pulses", p, 1);
      check_eq("go00_ups", u, 1);
      run_seg(2'b01, 10, p, u);
      check_eq("rv_up_pulses", p, X4 ? 1 : 0);
      check_eq("rv_up_ups", u, X4 ? 1 : 0);
      run_seg(2'b00, 10, p, u);
      check_eq("rv_dn_pulses", p, 1);
      check_eq("rv_dn_ups", u, 0);
      run_seg(2'b00, 5, p, u);
      check_eq("rv_hold_dir", o_up_down, 1'b0);
      check_eq("rv_hold_pulses", p, 0);
      check_eq("rv_err", o_err, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
